// File: rtl/c2h_scan_sched_pkg.sv
// Shared definitions for the C2H scan scheduler and its output register.
package c2h_scan_sched_pkg;

  localparam int C2H_DATA_W_DEF    = 128;
  localparam int C2H_PKT_BEATS_DEF = 256;
  localparam int C2H_CNT_W_DEF     = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ARB  = 2'd1,
    ST_XFER = 2'd2,
    ST_PAD  = 2'd3
  } c2h_state_e;

  // One-hot grant for two requesters; rr_ptr (0=src0, 1=src1) wins a tie.
  function automatic logic [1:0] rr_pick(input logic v0, input logic v1, input logic rr_ptr);
    logic [1:0] g;
    g = 2'b00;
    if (v0 && v1) g = rr_ptr ? 2'b10 : 2'b01;
    else if (v0)  g = 2'b01;
    else if (v1)  g = 2'b10;
    return g;
  endfunction

endpackage

// File: rtl/c2h_axis_oreg.sv
// 1-deep AXI-stream output register shared by the C2H channels.
// Data/last are held stable while valid is high and the sink is not ready.
module c2h_axis_oreg
  import c2h_scan_sched_pkg::*;
#(
  parameter int DATA_W = C2H_DATA_W_DEF
) (
  input  logic              usr_clk,
  input  logic              usr_rst,
  input  logic              clr,
  input  logic              load,
  input  logic [DATA_W-1:0] din,
  input  logic              lin,
  input  logic              tready,
  output logic [DATA_W-1:0] tdata,
  output logic              tvalid,
  output logic              tlast,
  output logic              can_load
);

  assign can_load = !tvalid || tready;

  // Load a new beat when the slot is free or draining; otherwise hold.
  always_ff @(posedge usr_clk or posedge usr_rst) begin
    if (usr_rst) begin
      tdata  <= '0;
      tvalid <= 1'b0;
      tlast  <= 1'b0;
    end else if (clr) begin
      tdata  <= '0;
      tvalid <= 1'b0;
      tlast  <= 1'b0;
    end else if (load && can_load) begin
      tdata  <= din;
      tvalid <= 1'b1;
      tlast  <= lin;
    end else if (tready) begin
      tvalid <= 1'b0;
      tlast  <= 1'b0;
    end
  end

endmodule

// File: rtl/c2h_scan_sched.sv
// C2H0 stream scheduler: packet-granular round-robin between two scan sources,
// zero-pads an interrupted packet up to its tlast so the descriptor is filled.
//
// state | meaning
// IDLE  | channel not running, no owner
// ARB   | running, waiting for a valid source to grant
// XFER  | forwarding owner beats until tlast
// PAD   | emitting zero beats until tlast after stop/run drop
module c2h_scan_sched
  import c2h_scan_sched_pkg::*;
#(
  parameter int DATA_W    = C2H_DATA_W_DEF,
  parameter int PKT_BEATS = C2H_PKT_BEATS_DEF,
  parameter int CNT_W     = C2H_CNT_W_DEF
) (
  input  logic                usr_clk,
  input  logic                usr_rst,
  input  logic                run_i,
  input  logic                stop_i,
  input  logic                c2h_rst_i,
  input  logic [DATA_W-1:0]   src0_tdata_i,
  input  logic                src0_valid_i,
  output logic                src0_ready_o,
  input  logic [DATA_W-1:0]   src1_tdata_i,
  input  logic                src1_valid_i,
  output logic                src1_ready_o,
  input  logic                s0_axis_c2h_tready_i,
  output logic [DATA_W-1:0]   s0_axis_c2h_tdata_o,
  output logic [DATA_W/8-1:0] s0_axis_c2h_tkeep_o,
  output logic [DATA_W/8-1:0] s0_axis_c2h_tuser_o,
  output logic                s0_axis_c2h_tvalid_o,
  output logic                s0_axis_c2h_tlast_o,
  output logic [1:0]          grant_o,
  output logic                busy_o,
  output logic [CNT_W-1:0]    pkt_cnt_o,
  output logic                trunc_err_o
);

  localparam int             BW        = $clog2(PKT_BEATS);
  localparam logic [BW-1:0]  LAST_BEAT = BW'(PKT_BEATS - 1);

  c2h_state_e        state;
  logic [1:0]        grant_q;
  logic              rr_ptr;
  logic [BW-1:0]     beat_cnt;
  logic [CNT_W-1:0]  pkt_cnt;
  logic              trunc_err;
  logic              can_load;
  logic              owner_valid;
  logic              ld;
  logic              ld_last;
  logic [DATA_W-1:0] ld_data;

  assign owner_valid  = (grant_q[0] && src0_valid_i) || (grant_q[1] && src1_valid_i);
  assign src0_ready_o = (state == ST_XFER) && grant_q[0] && can_load;
  assign src1_ready_o = (state == ST_XFER) && grant_q[1] && can_load;

  // Select what enters the output register this cycle: owner beat in XFER, zeros in PAD.
  always_comb begin
    ld      = 1'b0;
    ld_data = '0;
    ld_last = (beat_cnt == LAST_BEAT);
    if (!c2h_rst_i) begin
      if (state == ST_XFER && owner_valid && can_load) begin
        ld      = 1'b1;
        ld_data = grant_q[0] ? src0_tdata_i : src1_tdata_i;
      end else if (state == ST_PAD && can_load) begin
        ld = 1'b1;
      end
    end
  end

  // Sequencing FSM with arbiter, beat counter and packet counter.
  always_ff @(posedge usr_clk or posedge usr_rst) begin
    if (usr_rst) begin
      state     <= ST_IDLE;
      grant_q   <= 2'b00;
      rr_ptr    <= 1'b0;
      beat_cnt  <= '0;
      pkt_cnt   <= '0;
      trunc_err <= 1'b0;
    end else if (c2h_rst_i) begin
      state     <= ST_IDLE;
      grant_q   <= 2'b00;
      rr_ptr    <= 1'b0;
      beat_cnt  <= '0;
      pkt_cnt   <= '0;
      trunc_err <= 1'b0;
    end else begin
      if (ld) beat_cnt <= beat_cnt + BW'(1);
      case (state)
        ST_IDLE: begin
          grant_q <= 2'b00;
          if (run_i) state <= ST_ARB;
        end
        ST_ARB: begin
          if (!run_i || stop_i) begin
            state <= ST_IDLE;
          end else if (src0_valid_i || src1_valid_i) begin
            grant_q <= rr_pick(src0_valid_i, src1_valid_i, rr_ptr);
            state   <= ST_XFER;
          end
        end
        ST_XFER: begin
          if (ld && ld_last) begin
            // A stop landing on the final beat just ends the packet normally.
            rr_ptr  <= grant_q[0];
            pkt_cnt <= pkt_cnt + CNT_W'(1);
            grant_q <= 2'b00;
            state   <= (run_i && !stop_i) ? ST_ARB : ST_IDLE;
          end else if (stop_i || !run_i) begin
            // A beat taken this cycle makes the packet non-empty, so it must be padded.
            if (ld || beat_cnt != '0) begin
              state     <= ST_PAD;
              trunc_err <= 1'b1;
            end else begin
              state   <= ST_IDLE;
              grant_q <= 2'b00;
            end
          end
        end
        ST_PAD: begin
          if (ld && ld_last) begin
            pkt_cnt <= pkt_cnt + CNT_W'(1);
            grant_q <= 2'b00;
            state   <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  c2h_axis_oreg #(.DATA_W(DATA_W)) u_oreg (
    .usr_clk  (usr_clk),
    .usr_rst  (usr_rst),
    .clr      (c2h_rst_i),
    .load     (ld),
    .din      (ld_data),
    .lin      (ld_last),
    .tready   (s0_axis_c2h_tready_i),
    .tdata    (s0_axis_c2h_tdata_o),
    .tvalid   (s0_axis_c2h_tvalid_o),
    .tlast    (s0_axis_c2h_tlast_o),
    .can_load (can_load)
  );

  assign s0_axis_c2h_tkeep_o = '1;
  assign s0_axis_c2h_tuser_o = '0;
  assign grant_o             = grant_q;
  assign busy_o              = (state != ST_IDLE);
  assign pkt_cnt_o           = pkt_cnt;
  assign trunc_err_o         = trunc_err;

endmodule

// File: tb/tb_c2h_scan_sched.sv
// Directed bench for c2h_scan_sched with a beat scoreboard on the C2H stream.
module tb_c2h_scan_sched;

  localparam int DATA_W = 128;
  localparam int PKT    = 256;
  localparam int CNT_W  = 32;

  typedef struct {
    logic [DATA_W-1:0] d;
    logic              l;
  } beat_t;

  logic usr_clk = 1'b0;
  logic usr_rst, run_i, stop_i, c2h_rst_i;
  logic [DATA_W-1:0] src0_tdata, src1_tdata;
  logic src0_valid, src1_valid, src0_ready, src1_ready;
  logic tready;
  logic [DATA_W-1:0] tdata;
  logic [DATA_W/8-1:0] tkeep, tuser;
  logic tvalid, tlast;
  logic [1:0] grant;
  logic busy;
  logic [CNT_W-1:0] pkt_cnt;
  logic trunc_err;

  always #5 usr_clk = ~usr_clk;

  c2h_scan_sched #(.DATA_W(DATA_W), .PKT_BEATS(PKT), .CNT_W(CNT_W)) dut (
    .usr_clk              (usr_clk),
    .usr_rst              (usr_rst),
    .run_i                (run_i),
    .stop_i               (stop_i),
    .c2h_rst_i            (c2h_rst_i),
    .src0_tdata_i         (src0_tdata),
    .src0_valid_i         (src0_valid),
    .src0_ready_o         (src0_ready),
    .src1_tdata_i         (src1_tdata),
    .src1_valid_i         (src1_valid),
    .src1_ready_o         (src1_ready),
    .s0_axis_c2h_tready_i (tready),
    .s0_axis_c2h_tdata_o  (tdata),
    .s0_axis_c2h_tkeep_o  (tkeep),
    .s0_axis_c2h_tuser_o  (tuser),
    .s0_axis_c2h_tvalid_o (tvalid),
    .s0_axis_c2h_tlast_o  (tlast),
    .grant_o              (grant),
    .busy_o               (busy),
    .pkt_cnt_o            (pkt_cnt),
    .trunc_err_o          (trunc_err)
  );

  int checks = 0;
  int errors = 0;

  beat_t sb[$];
  int model_beat  = 0;   // index of next expected beat within the packet
  int pushed_src  = 0;   // source beats accepted so far
  int src_limit   = 0;   // sources stop offering beats at this total
  int out_pkts    = 0;   // tlast beats consumed at the sink
  int seq0 = 0, seq1 = 0, cyc = 0;
  bit src0_en = 0, src1_en = 0, tr_toggle = 0, check_owner = 0;
  bit prev_stall = 0;
  logic [DATA_W-1:0] prev_d;
  logic prev_l;
  logic [3:0] tr_pat = 4'b1001;

  task automatic chk(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [DATA_W-1:0] mk(input int src, input int seq);
    return {32'h5500_0000 | 32'(src), 64'h0123_4567_89AB_CDEF, 32'(seq)};
  endfunction

  task automatic push_exp(input logic [DATA_W-1:0] d, input bit from_src);
    beat_t b;
    b.d = d;
    b.l = (model_beat == PKT - 1);
    sb.push_back(b);
    model_beat = (model_beat + 1) % PKT;
    if (from_src) pushed_src++;
  endtask

  // Source and sink models: drive just after posedge, evaluate handshakes just after negedge.
  initial begin
    beat_t e;
    src0_valid = 0; src1_valid = 0; tready = 1;
    src0_tdata = '0; src1_tdata = '0;
    forever begin
      @(posedge usr_clk); #1;
      cyc++;
      tready     = tr_toggle ? tr_pat[cyc % 4] : 1'b1;
      src0_valid = src0_en && (pushed_src < src_limit);
      src1_valid = src1_en && (pushed_src < src_limit);
      src0_tdata = mk(0, seq0);
      src1_tdata = mk(1, seq1);
      @(negedge usr_clk); #1;
      if (src0_valid && src0_ready) begin push_exp(src0_tdata, 1); seq0++; end
      if (src1_valid && src1_ready) begin push_exp(src1_tdata, 1); seq1++; end
      if (prev_stall) begin
        chk("stall_valid", DATA_W'(tvalid), DATA_W'(1));
        chk("stall_data", tdata, prev_d);
        chk("stall_last", DATA_W'(tlast), DATA_W'(prev_l));
      end
      if (tvalid && tready) begin
        if (sb.size() == 0) begin
          chk("sb_underflow", DATA_W'(1), DATA_W'(0));
        end else begin
          e = sb.pop_front();
          chk("beat_data", tdata, e.d);
          chk("beat_last", DATA_W'(tlast), DATA_W'(e.l));
          if (check_owner)
            chk("owner", DATA_W'(tdata[DATA_W-1:DATA_W-32]),
                DATA_W'(32'h5500_0000 | 32'(out_pkts % 2)));
        end
        if (tlast) out_pkts++;
      end
      prev_stall = tvalid && !tready;
      prev_d     = tdata;
      prev_l     = tlast;
    end
  end

  task automatic wait_pkts(input int n);
    for (int i = 0; i < 5000 && out_pkts < n; i++) begin
      @(negedge usr_clk); #2;
    end
    chk("wait_pkts", DATA_W'(out_pkts >= n), DATA_W'(1));
  endtask

  task automatic wait_pushed(input int n);
    for (int i = 0; i < 5000 && pushed_src < n; i++) begin
      @(negedge usr_clk); #2;
    end
    chk("wait_pushed", DATA_W'(pushed_src >= n), DATA_W'(1));
  endtask

  task automatic wait_beat(input int n);
    for (int i = 0; i < 5000 && model_beat != n; i++) begin
      @(negedge usr_clk); #2;
    end
    chk("wait_beat", DATA_W'(model_beat == n), DATA_W'(1));
  endtask

  initial begin
    usr_rst = 1; run_i = 0; stop_i = 0; c2h_rst_i = 0;
    repeat (3) @(negedge usr_clk);
    #2;
    chk("rst_tvalid", DATA_W'(tvalid), '0);
    chk("rst_tlast", DATA_W'(tlast), '0);
    chk("rst_tdata", tdata, '0);
    chk("rst_tkeep", DATA_W'(tkeep), DATA_W'(16'hFFFF));
    chk("rst_tuser", DATA_W'(tuser), '0);
    chk("rst_grant", DATA_W'(grant), '0);
    chk("rst_busy", DATA_W'(busy), '0);
    chk("rst_pkt_cnt", DATA_W'(pkt_cnt), '0);
    chk("rst_trunc", DATA_W'(trunc_err), '0);
    chk("rst_ready", DATA_W'({src0_ready, src1_ready}), '0);
    @(negedge usr_clk); usr_rst = 0;

    // Tests 1-3: src0 streams, src1 joins mid-packet, then tready stalls in packet 3.
    check_owner = 1;
    src_limit = 4 * PKT;
    run_i = 1; src0_en = 1;
    repeat (50) @(negedge usr_clk);
    #2;
    chk("t1_grant", DATA_W'(grant), DATA_W'(2'b01));
    chk("t1_busy", DATA_W'(busy), DATA_W'(1));
    src1_en = 1;
    repeat (5) @(negedge usr_clk);
    #2;
    chk("t1_no_preempt", DATA_W'(src1_ready), '0);
    wait_pkts(1);
    chk("t1_pkt_cnt", DATA_W'(pkt_cnt), DATA_W'(1));
    repeat (3) @(negedge usr_clk);
    #2;
    chk("t1_grant_next", DATA_W'(grant), DATA_W'(2'b10));
    wait_pkts(3);
    chk("t2_pkt_cnt", DATA_W'(pkt_cnt), DATA_W'(3));
    tr_toggle = 1;
    wait_pkts(4);
    tr_toggle = 0;
    chk("t3_pkt_cnt", DATA_W'(pkt_cnt), DATA_W'(4));
    repeat (3) @(negedge usr_clk);
    #2;
    chk("arb_wait_busy", DATA_W'(busy), DATA_W'(1));
    chk("arb_wait_grant", DATA_W'(grant), '0);
    run_i = 0;
    @(negedge usr_clk); #2;
    chk("arb_run_low_idle", DATA_W'(busy), '0);

    // Test 4: stop after 10 beats -> 246 zero beats.
    src1_en = 0;
    src_limit = pushed_src + 10;
    run_i = 1;
    wait_pushed(src_limit);
    repeat (3) @(negedge usr_clk);
    #2;
    chk("t4_no_bubble", DATA_W'(tvalid), '0);
    chk("t4_busy", DATA_W'(busy), DATA_W'(1));
    @(negedge usr_clk);
    check_owner = 0;
    stop_i = 1;
    for (int i = 0; i < PKT - 10; i++) push_exp('0, 0);
    @(negedge usr_clk);
    stop_i = 0; run_i = 0;
    wait_pkts(5);
    chk("t4_trunc", DATA_W'(trunc_err), DATA_W'(1));
    chk("t4_pkt_cnt", DATA_W'(pkt_cnt), DATA_W'(5));
    repeat (2) @(negedge usr_clk);
    #2;
    chk("t4_idle", DATA_W'(busy), '0);
    chk("t4_ready", DATA_W'(src0_ready), '0);
    chk("t4_sb_empty", DATA_W'(sb.size()), '0);

    // Test 5: c2h_rst_i at beat 100.
    src_limit = pushed_src + 300;
    run_i = 1;
    wait_beat(100);
    @(negedge usr_clk);
    c2h_rst_i = 1; run_i = 0; src0_en = 0;
    @(negedge usr_clk);
    c2h_rst_i = 0;
    #2;
    sb.delete();
    model_beat = 0;
    out_pkts = 0;
    chk("t5_tvalid", DATA_W'(tvalid), '0);
    chk("t5_grant", DATA_W'(grant), '0);
    chk("t5_busy", DATA_W'(busy), '0);
    chk("t5_trunc", DATA_W'(trunc_err), '0);
    chk("t5_pkt_cnt", DATA_W'(pkt_cnt), '0);
    src_limit = pushed_src + PKT;
    run_i = 1; src0_en = 1;
    wait_pkts(1);
    chk("t5_pkt_cnt_after", DATA_W'(pkt_cnt), DATA_W'(1));

    // Test 6: stop coincident with the tlast load.
    src_limit = pushed_src + PKT;
    wait_beat(PKT - 1);
    @(negedge usr_clk);
    stop_i = 1;
    @(negedge usr_clk);
    stop_i = 0; run_i = 0;
    #2;
    chk("t6_idle", DATA_W'(busy), '0);
    chk("t6_pkt_cnt", DATA_W'(pkt_cnt), DATA_W'(2));
    chk("t6_trunc", DATA_W'(trunc_err), '0);
    wait_pkts(2);
    repeat (2) @(negedge usr_clk);
    #2;
    chk("t6_still_idle", DATA_W'(busy), '0);
    chk("t6_sb_empty", DATA_W'(sb.size()), '0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
